td4_core: RTL and testbench

Single-cycle TD4 execution core: program counter, registers A and B, carry flag, and 4-bit input/output ports. It drives the 4-bit instruction address to the program ROM and consumes the 8-bit instruction word returned combinationally in the same cycle. One instruction retires per enabled clock edge. It sits directly downstream of the program memory and is the only consumer of its data.

---
 rtl/td4_pkg.sv | 31 +++
 rtl/td4_if.sv | 13 +
 rtl/td4_decode.sv | 63 ++++++
 rtl/td4_core.sv | 93 +++++++++
 tb/tb_td4_core.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/td4_pkg.sv
// Shared TD4 definitions: opcode encodings, reset values and decoder control types.
package td4_pkg;

  localparam logic [3:0] OP_ADD_A    = 4'b0000;
  localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
  localparam logic [3:0] OP_IN_A     = 4'b0010;
  localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
  localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
  localparam logic [3:0] OP_ADD_B    = 4'b0101;
  localparam logic [3:0] OP_IN_B     = 4'b0110;
  localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
  localparam logic [3:0] OP_OUT_B    = 4'b1001;
  localparam logic [3:0] OP_OUT_IM   = 4'b1011;
  localparam logic [3:0] OP_JNC      = 4'b1110;
  localparam logic [3:0] OP_JMP      = 4'b1111;

  localparam logic [3:0] RST_PC  = 4'h0;
  localparam logic [3:0] RST_A   = 4'h0;
  localparam logic [3:0] RST_B   = 4'h0;
  localparam logic       RST_C   = 1'b0;
  localparam logic [3:0] RST_OUT = 4'h0;

  // Operand source feeding the adder and every register write.
  typedef enum logic [1:0] {
    SRC_IM = 2'd0,
    SRC_A  = 2'd1,
    SRC_B  = 2'd2,
    SRC_IN = 2'd3
  } src_sel_t;

endpackage

// File: rtl/td4_if.sv
// Program-memory and I/O port bundle of the TD4 core; the core is the master side.
interface td4_if;

  logic       CE;
  logic [3:0] ADDR;
  logic [7:0] DATA;
  logic [3:0] IN;
  logic [3:0] OUT;

  modport master (input CE, DATA, IN, output ADDR, OUT);
  modport slave  (output CE, DATA, IN, input ADDR, OUT);

endinterface

// File: rtl/td4_decode.sv
// Combinational TD4 instruction decoder: opcode and carry to load enables and operand select.
module td4_decode
  import td4_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       c,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_out,
  output logic       ld_pc_jump,
  output src_sel_t   src_sel,
  output logic       add_en
);

  always_comb begin
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    ld_out     = 1'b0;
    ld_pc_jump = 1'b0;
    src_sel    = SRC_IM;
    add_en     = 1'b0;
    case (opcode)
      OP_ADD_A: begin
        ld_a    = 1'b1;
        src_sel = SRC_A;
        add_en  = 1'b1;
      end
      OP_ADD_B: begin
        ld_b    = 1'b1;
        src_sel = SRC_B;
        add_en  = 1'b1;
      end
      OP_MOV_A_IM: ld_a = 1'b1;
      OP_MOV_B_IM: ld_b = 1'b1;
      OP_MOV_A_B: begin
        ld_a    = 1'b1;
        src_sel = SRC_B;
      end
      OP_MOV_B_A: begin
        ld_b    = 1'b1;
        src_sel = SRC_A;
      end
      OP_IN_A: begin
        ld_a    = 1'b1;
        src_sel = SRC_IN;
      end
      OP_IN_B: begin
        ld_b    = 1'b1;
        src_sel = SRC_IN;
      end
      OP_OUT_B: begin
        ld_out  = 1'b1;
        src_sel = SRC_B;
      end
      OP_OUT_IM: ld_out = 1'b1;
      OP_JMP:    ld_pc_jump = 1'b1;
      // JNC sees the carry left behind by the previous instruction.
      OP_JNC:    ld_pc_jump = ~c;
      default:   ;
    endcase
  end

endmodule

// File: rtl/td4_core.sv
// Single-cycle TD4 core: PC, A, B, carry and OUT registers, 4-bit adder and PC incrementer.
module td4_core
  import td4_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  td4_if.master bus
);

  logic [3:0] pc_reg, pc_next;
  logic [3:0] a_reg, a_next;
  logic [3:0] b_reg, b_next;
  logic       c_reg, c_next;
  logic [3:0] out_reg, out_next;

  logic [3:0] opcode, im;
  logic       ld_a, ld_b, ld_out, ld_pc_jump, add_en;
  src_sel_t   src_sel;
  logic [3:0] operand, addend, sum, pc_inc;
  logic [4:0] carry;

  assign opcode = bus.DATA[7:4];
  assign im     = bus.DATA[3:0];

  td4_decode u_decode (
    .opcode     (opcode),
    .c          (c_reg),
    .ld_a       (ld_a),
    .ld_b       (ld_b),
    .ld_out     (ld_out),
    .ld_pc_jump (ld_pc_jump),
    .src_sel    (src_sel),
    .add_en     (add_en)
  );

  always_comb begin
    case (src_sel)
      SRC_A:   operand = a_reg;
      SRC_B:   operand = b_reg;
      SRC_IN:  operand = bus.IN;
      default: operand = im;
    endcase
  end

  // Non-ADD instructions add zero, so their carry-out is 0 and clears C for free.
  assign addend   = add_en ? im : 4'h0;
  assign carry[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_add
      assign sum[gi]     = operand[gi] ^ addend[gi] ^ carry[gi];
      assign carry[gi+1] = (operand[gi] & addend[gi]) | (carry[gi] & (operand[gi] ^ addend[gi]));
    end
  endgenerate

  assign pc_inc = pc_reg + 4'd1;

  always_comb begin
    pc_next  = pc_reg;
    a_next   = a_reg;
    b_next   = b_reg;
    c_next   = c_reg;
    out_next = out_reg;
    if (bus.CE) begin
      pc_next = ld_pc_jump ? im : pc_inc;
      c_next  = carry[4];
      if (ld_a)   a_next   = sum;
      if (ld_b)   b_next   = sum;
      if (ld_out) out_next = sum;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_reg  <= RST_PC;
      a_reg   <= RST_A;
      b_reg   <= RST_B;
      c_reg   <= RST_C;
      out_reg <= RST_OUT;
    end else begin
      pc_reg  <= pc_next;
      a_reg   <= a_next;
      b_reg   <= b_next;
      c_reg   <= c_next;
      out_reg <= out_next;
    end
  end

  assign bus.ADDR = pc_reg;
  assign bus.OUT  = out_reg;

endmodule

// File: tb/tb_td4_core.sv
// Self-checking bench for td4_core: ISA-level model feeds a scoreboard of expected ADDR/OUT per edge.
module tb_td4_core;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] rom [16];

  td4_if bus ();
  assign bus.DATA = rom[bus.ADDR];

  td4_core dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] addr;
    logic [3:0] out;
  } exp_t;

  exp_t sb_q[$];

  logic [3:0] m_pc, m_a, m_b, m_out;
  logic       m_c;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = 4'h0;
    m_a   = 4'h0;
    m_b   = 4'h0;
    m_c   = 1'b0;
    m_out = 4'h0;
  endtask

  task automatic model_exec(input logic [3:0] in_val);
    logic [7:0] instr;
    logic [3:0] op, im, npc;
    logic [4:0] s;
    logic       nc;
    instr = rom[m_pc];
    op    = instr[7:4];
    im    = instr[3:0];
    npc   = m_pc + 4'd1;
    nc    = 1'b0;
    case (op)
      4'h0: begin s = {1'b0, m_a} + {1'b0, im}; m_a = s[3:0]; nc = s[4]; end
      4'h5: begin s = {1'b0, m_b} + {1'b0, im}; m_b = s[3:0]; nc = s[4]; end
      4'h3: m_a = im;
      4'h7: m_b = im;
      4'h1: m_a = m_b;
      4'h4: m_b = m_a;
      4'h2: m_a = in_val;
      4'h6: m_b = in_val;
      4'h9: m_out = m_b;
      4'hB: m_out = im;
      4'hF: npc = im;
      4'hE: if (!m_c) npc = im;
      default: ;
    endcase
    m_c  = nc;
    m_pc = npc;
  endtask

  // One clock edge: predict, push, clock, pop and compare.
  task automatic step(input logic ce, input logic rst, input string tag);
    exp_t e;
    bus.CE = ce;
    RST    = rst;
    if (rst) model_reset();
    else if (ce) model_exec(bus.IN);
    e.addr = m_pc;
    e.out  = m_out;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    $display("%s: ce=%0b rst=%0b addr=%0h out=%0h (exp %0h/%0h)", tag, ce, rst, bus.ADDR, bus.OUT, e.addr, e.out);
    check({tag, "_addr"}, 8'(bus.ADDR), 8'(e.addr));
    check({tag, "_out"}, 8'(bus.OUT), 8'(e.out));
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
  endtask

  logic [3:0] t3_out [6] = '{4'h3, 4'hC, 4'hC, 4'h3, 4'hC, 4'hC};
  logic [3:0] t3_addr[6] = '{4'h1, 4'h2, 4'h0, 4'h1, 4'h2, 4'h0};

  initial begin
    bus.CE = 1'b0;
    bus.IN = 4'h0;
    RST    = 1'b1;
    model_reset();

    // Reset with random program contents and input
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    bus.IN = 4'($urandom);
    step(1'($urandom_range(0, 1)), 1'b1, "t1_rst0");
    step(1'($urandom_range(0, 1)), 1'b1, "t1_rst1");
    check("t1_addr0", 8'(bus.ADDR), 8'h0);
    check("t1_out0", 8'(bus.OUT), 8'h0);
    rom[0] = 8'hB6;
    step(1'b1, 1'b0, "t1_exec");
    check("t1_first_exec", 8'(bus.OUT), 8'h6);

    // Carry and JNC
    fill_nop();
    rom[0] = 8'h33; rom[1] = 8'h0E; rom[2] = 8'hE0; rom[3] = 8'hB5;
    rom[4] = 8'hE7; rom[7] = 8'h40; rom[8] = 8'h90;
    step(1'b1, 1'b1, "t2_rst");
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, "t2");
    check("t2_jnc_not_taken", 8'(bus.ADDR), 8'h3);
    step(1'b1, 1'b0, "t2");
    check("t2_out_im", 8'(bus.OUT), 8'h5);
    step(1'b1, 1'b0, "t2");
    check("t2_c_cleared", 8'(bus.ADDR), 8'h7);
    step(1'b1, 1'b0, "t2");
    step(1'b1, 1'b0, "t2");
    check("t2_a_low_bits", 8'(bus.OUT), 8'h1);

    // Loop
    fill_nop();
    rom[0] = 8'hB3; rom[1] = 8'hBC; rom[2] = 8'hF0;
    step(1'b1, 1'b1, "t3_rst");
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, "t3");
      check("t3_addr_seq", 8'(bus.ADDR), 8'(t3_addr[k]));
      check("t3_out_seq", 8'(bus.OUT), 8'(t3_out[k]));
    end

    // Data path from IN, IN changes after it is consumed
    fill_nop();
    rom[0] = 8'h20; rom[1] = 8'h40; rom[2] = 8'h90;
    bus.IN = 4'h9;
    step(1'b1, 1'b1, "t4_rst");
    step(1'b1, 1'b0, "t4");
    bus.IN = 4'h2;
    step(1'b1, 1'b0, "t4");
    step(1'b1, 1'b0, "t4");
    check("t4_out_in", 8'(bus.OUT), 8'h9);

    // NOP wrap and clock enable
    fill_nop();
    step(1'b1, 1'b1, "t5_rst");
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, "t5");
    check("t5_wrap", 8'(bus.ADDR), 8'h0);
    for (int k = 0; k < 8; k++) step(1'(k % 2), 1'b0, "t5_ce");
    check("t5_ce_count", 8'(bus.ADDR), 8'h4);

    // Reset in the middle of a program
    fill_nop();
    rom[0] = 8'h37; rom[1] = 8'h7F; rom[2] = 8'h0F; rom[3] = 8'hB9;
    rom[4] = 8'h0F; rom[5] = 8'hB7;
    step(1'b1, 1'b1, "t6_rst0");
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, "t6");
    check("t6_pre_addr", 8'(bus.ADDR), 8'h5);
    check("t6_pre_out", 8'(bus.OUT), 8'h9);
    step(1'b1, 1'b1, "t6_rst1");
    check("t6_rst_out", 8'(bus.OUT), 8'h0);
    check("t6_rst_addr", 8'(bus.ADDR), 8'h0);
    fill_nop();
    rom[0] = 8'hE2; rom[1] = 8'hB0; rom[2] = 8'h51; rom[3] = 8'h90;
    rom[4] = 8'h0F; rom[5] = 8'hE7; rom[6] = 8'hB0; rom[7] = 8'h40; rom[8] = 8'h90;
    step(1'b1, 1'b0, "t6");
    check("t6_c_zero", 8'(bus.ADDR), 8'h2);
    step(1'b1, 1'b0, "t6");
    step(1'b1, 1'b0, "t6");
    check("t6_b_zero", 8'(bus.OUT), 8'h1);
    step(1'b1, 1'b0, "t6");
    step(1'b1, 1'b0, "t6");
    check("t6_a_zero", 8'(bus.ADDR), 8'h7);
    step(1'b1, 1'b0, "t6");
    step(1'b1, 1'b0, "t6");
    check("t6_a_path", 8'(bus.OUT), 8'hF);

    check("sb_drained", 8'(sb_q.size()), 8'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
